riscv_dmem_arbiter: RTL
=======================

// Module: riscv_dmem_arbiter
// PURPOSE
//  Shares the single synchronous-read data-memory port between the RISC-V CPU and a debug/loader master
//  (UART bootloader, memory inspector). Sits between both masters and the data memory; the memory
//  contract is: registered read, 1-cycle latency, write on clock edge when enabled.
//  Fixed CPU priority, starvation guard for debug, optional debug bus lock with bounded duration.
// PARAMETERS
//  MAX_WAIT   default 8    cycles debug may wait under contention before forced grant (>=1)
//  MAX_LOCK   default 64   max consecutive cycles a debug lock may hold the port (>=1)
//  CNT_WIDTH  default 16   width of statistics counters (ARB_STATS_EN only)
// PORTS
//  clk            in   1   system clock, all state on rising edge
//  rst_n          in   1   asynchronous reset, active-low
//  cpu_req        in   1   CPU access request
//  cpu_we         in   1   1=write, 0=read
//  cpu_addr       in   32  byte address
//  cpu_wdata      in   32  write data
//  cpu_gnt        out  1   transfer accepted this cycle (combinational)
//  cpu_rvalid     out  1   read data valid (1 cycle after granted read)
//  cpu_rdata      out  32  read data
//  dbg_req/dbg_we/dbg_addr/dbg_wdata  in 1/1/32/32  debug master, same meaning as CPU
//  dbg_lock       in   1   hold port for debug after this transfer
//  dbg_gnt/dbg_rvalid/dbg_rdata       out 1/1/32    same meaning as CPU
//  mem_en         out  1   a transfer is issued this cycle
//  mem_we         out  1   write strobe (only when mem_en)
//  mem_addr       out  32  address to memory
//  mem_wdata      out  32  write data to memory
//  mem_rdata      in   32  memory read data, valid 1 cycle after issue
// BEHAVIOUR
//  - Transfer occurs in any cycle with x_req & x_gnt; at most one gnt high per cycle.
//  - FSM states: IDLE, LOCKED, YIELD.
//    IDLE: cpu_req wins; dbg wins if cpu_req=0, or if wait_cnt==MAX_WAIT.
//          debug transfer with dbg_lock=1 -> LOCKED, lock_cnt cleared.
//    LOCKED: cpu_gnt=0; dbg_gnt=dbg_req. dbg_lock=0 in any cycle -> IDLE.
//          lock_cnt increments each cycle; lock_cnt==MAX_LOCK-1 -> YIELD (forced release).
//    YIELD: 1 cycle; CPU absolute priority, dbg_gnt=0 even if cpu_req=0; -> IDLE.
//  - wait_cnt: +1 per cycle dbg_req & !dbg_gnt, saturates at MAX_WAIT; cleared on dbg grant or dbg_req=0.
//  - Memory mux: winner's addr/wdata/we drive mem_*; mem_en = any grant; no grant -> mem_we=0,
//    mem_addr/mem_wdata follow CPU inputs.
//  - Read return: owner and is_read registered on grant; x_rvalid = 1 exactly 1 cycle after a granted
//    read by x; x_rdata = mem_rdata when x_rvalid else 32'h0. Granted writes produce no rvalid.
//  - Back-to-back: new grant allowed in rvalid cycle; returns are in order, never overlap.
//  - Reset (rst_n=0, async, any time incl. mid-lock): state=IDLE, wait_cnt=lock_cnt=0, all gnt=0,
//    all rvalid=0, mem_en=mem_we=0; pending read return dropped. First grant possible on the first
//    clock edge after deassertion.
// CONFIGURATION
//  ARB_STATS_EN defined: adds outputs cpu_stall_cnt [CNT_WIDTH] (cycles cpu_req & !cpu_gnt) and
//    dbg_xfer_cnt [CNT_WIDTH] (granted debug transfers); both saturate at all-ones, reset to 0.
//  ARB_STATS_EN undefined: ports and counters absent; arbitration behaviour identical.
// TESTING
//  - CPU read 0x00800010 alone -> cpu_gnt same cycle, mem_addr=0x00800010, cpu_rvalid next cycle with mem word.
//  - Both req continuously, MAX_WAIT=8 -> CPU granted 8 cycles, dbg granted on 9th, pattern repeats.
//  - dbg write with lock=1, then 3 locked reads while cpu_req=1 -> cpu_gnt=0 throughout; lock=0 -> CPU next.
//  - Lock held, MAX_LOCK=64 -> after 64 locked cycles 1 YIELD cycle, cpu_gnt=1, dbg_gnt=0.
//  - rst_n low in cycle after granted read, mid-lock -> rvalid=0 immediately, state IDLE, no stale rdata.
//  - ARB_STATS_EN: 5 stalled CPU cycles, 3 dbg transfers -> cpu_stall_cnt=5, dbg_xfer_cnt=3.

Source files
------------

// File: rtl/riscv_dmem_arbiter.sv
// Data-memory port arbiter: CPU priority, debug starvation guard, bounded debug lock.
// Define ARB_STATS_EN to add the cpu_stall_cnt / dbg_xfer_cnt statistics outputs.
module riscv_dmem_arbiter #(
    parameter int MAX_WAIT  = 8,
    parameter int MAX_LOCK  = 64,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [31:0]          cpu_addr,
    input  logic [31:0]          cpu_wdata,
    output logic                 cpu_gnt,
    output logic                 cpu_rvalid,
    output logic [31:0]          cpu_rdata,
    input  logic                 dbg_req,
    input  logic                 dbg_we,
    input  logic [31:0]          dbg_addr,
    input  logic [31:0]          dbg_wdata,
    input  logic                 dbg_lock,
    output logic                 dbg_gnt,
    output logic                 dbg_rvalid,
    output logic [31:0]          dbg_rdata,
`ifdef ARB_STATS_EN
    output logic [CNT_WIDTH-1:0] cpu_stall_cnt,
    output logic [CNT_WIDTH-1:0] dbg_xfer_cnt,
`endif
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int LW = $clog2(MAX_LOCK + 1);

    typedef enum logic [1:0] {IDLE, LOCKED, YIELD} state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [LW-1:0] lock_q, lock_d;
    logic          wait_full;
    logic          cpu_rv_q, dbg_rv_q;

    assign wait_full = (wait_q == WW'(MAX_WAIT));

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        unique case (state_q)
            IDLE: begin
                dbg_gnt = dbg_req & (~cpu_req | wait_full);
                cpu_gnt = cpu_req & ~dbg_gnt;
                if (dbg_gnt & dbg_lock) begin
                    state_d = LOCKED;
                    lock_d  = '0;
                end
            end
            LOCKED: begin
                dbg_gnt = dbg_req;
                lock_d  = lock_q + 1'b1;
                if (!dbg_lock)
                    state_d = IDLE;
                else if (lock_q == LW'(MAX_LOCK - 1))
                    state_d = YIELD;
            end
            YIELD: begin
                cpu_gnt = cpu_req;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Nothing may reach memory while reset is asserted
        if (!rst_n) begin
            cpu_gnt = 1'b0;
            dbg_gnt = 1'b0;
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (!dbg_req || dbg_gnt)
            wait_d = '0;
        else if (!wait_full)
            wait_d = wait_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            lock_q   <= '0;
            cpu_rv_q <= 1'b0;
            dbg_rv_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            lock_q   <= lock_d;
            cpu_rv_q <= cpu_gnt & ~cpu_we;
            dbg_rv_q <= dbg_gnt & ~dbg_we;
        end
    end

    assign mem_en    = cpu_gnt | dbg_gnt;
    assign mem_we    = dbg_gnt ? dbg_we : (cpu_gnt & cpu_we);
    assign mem_addr  = dbg_gnt ? dbg_addr : cpu_addr;
    assign mem_wdata = dbg_gnt ? dbg_wdata : cpu_wdata;

    assign cpu_rvalid = cpu_rv_q;
    assign dbg_rvalid = dbg_rv_q;
    assign cpu_rdata  = cpu_rv_q ? mem_rdata : 32'h0;
    assign dbg_rdata  = dbg_rv_q ? mem_rdata : 32'h0;

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_stall_cnt <= '0;
            dbg_xfer_cnt  <= '0;
        end else begin
            if (cpu_req && !cpu_gnt && !(&cpu_stall_cnt))
                cpu_stall_cnt <= cpu_stall_cnt + 1'b1;
            if (dbg_gnt && !(&dbg_xfer_cnt))
                dbg_xfer_cnt <= dbg_xfer_cnt + 1'b1;
        end
    end
`endif

endmodule
